// File: rtl/rotor_pkg.sv
// Shared definitions for the parametrised rotor.
//   shift_mode_e  : intra-group swap mode encodings (SHIFT_M0..SHIFT_M3)
//   rotor_state_e : load FSM states (EMPTY / LOAD / READY)
//   swap_src()    : group swap map, gives source slot for destination slot k
//   perm_idx()    : stride permutation, source index feeding destination i
package rotor_pkg;

    localparam int GROUP_SIZE = 4;

    typedef enum logic [1:0] {
        SHIFT_M0 = 2'd0,
        SHIFT_M1 = 2'd1,
        SHIFT_M2 = 2'd2,
        SHIFT_M3 = 2'd3
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } rotor_state_e;

    // Maps are packed with slot k at bits [2k+1:2k], so the literals read
    // right-to-left: SHIFT_M0 sources {1,3,0,2} for slots 0..3.
    function automatic logic [1:0] swap_src(shift_mode_e mode, logic [1:0] k);
        logic [7:0] map;
        map = {2'd2, 2'd0, 2'd3, 2'd1};
        case (mode)
            SHIFT_M0: map = {2'd2, 2'd0, 2'd3, 2'd1};
            SHIFT_M1: map = {2'd1, 2'd3, 2'd0, 2'd2};
            SHIFT_M2: map = {2'd0, 2'd3, 2'd2, 2'd1};
            SHIFT_M3: map = {2'd1, 2'd2, 2'd3, 2'd0};
            default:  map = {2'd2, 2'd0, 2'd3, 2'd1};
        endcase
        return map[2*int'(k) +: 2];
    endfunction

    // An odd stride is coprime with a power-of-two depth, so this is a bijection.
    function automatic int perm_idx(int i, int stride, int offset, int depth);
        return (i * stride + offset) % depth;
    endfunction

endpackage

// File: rtl/rotor_cam_search.sv
// DEPTH-way equality compare against key with lowest-index priority.
//   tbl  : full table contents
//   key  : symbol to find
//   idx  : lowest index holding key, 0 when absent
//   miss : no entry holds key
module rotor_cam_search #(
    parameter int SYM_W = 6,
    parameter int DEPTH = 64
) (
    input  logic [DEPTH-1:0][SYM_W-1:0] tbl,
    input  logic [SYM_W-1:0]            key,
    output logic [SYM_W-1:0]            idx,
    output logic                        miss
);

    // NOTE: every output of an always_comb gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        idx  = '0;
        miss = 1'b1;
        // Scanning downward lets the lowest matching index win last.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tbl[i] == key) begin
                idx  = SYM_W'(i);
                miss = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rotor_perm_param.sv
// Parametrised rotor: serially loaded DEPTH-entry substitution table with
// registered forward/backward lookups and a swap+stride step permutation.
//   clear                      : back to EMPTY, table kept, load pointer zeroed
//   load_valid/load_data       : one table entry per beat; load_done in READY
//   step/shift_mode            : permute table (READY only)
//   fwd_valid/fwd_in -> fwd_out/fwd_out_valid       : table[fwd_in]
//   bwd_valid/bwd_in -> bwd_out/bwd_out_valid/miss  : lowest index of bwd_in
//   crypt_mode -> shift_amount : top two bits of bwd result or fwd index
//   step_cnt                   : steps since the table became READY
module rotor_perm_param
    import rotor_pkg::*;
#(
    parameter int SYM_W  = 6,
    parameter int STRIDE = 5,
    parameter int OFFSET = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [SYM_W-1:0] load_data,
    output logic             load_done,
    input  logic             step,
    input  logic [1:0]       shift_mode,
    input  logic             crypt_mode,
    input  logic             fwd_valid,
    input  logic [SYM_W-1:0] fwd_in,
    output logic [SYM_W-1:0] fwd_out,
    output logic             fwd_out_valid,
    input  logic             bwd_valid,
    input  logic [SYM_W-1:0] bwd_in,
    output logic [SYM_W-1:0] bwd_out,
    output logic             bwd_out_valid,
    output logic             bwd_miss,
    output logic [1:0]       shift_amount,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int DEPTH = 2 ** SYM_W;

    if (SYM_W < 2) begin : g_bad_sym_w
        $error("rotor_perm_param: SYM_W must be >= 2 so DEPTH is a multiple of 4");
    end
    if (STRIDE % 2 == 0) begin : g_bad_stride
        $error("rotor_perm_param: STRIDE must be odd");
    end
    if (OFFSET < 0 || OFFSET >= DEPTH) begin : g_bad_offset
        $error("rotor_perm_param: OFFSET must lie in 0..DEPTH-1");
    end

    rotor_state_e                state_q, state_d;
    logic [SYM_W-1:0]            load_ptr_q, load_ptr_d;
    logic [DEPTH-1:0][SYM_W-1:0] tbl_q, tbl_d;
    logic [CNT_W-1:0]            step_cnt_q, step_cnt_d;
    logic [SYM_W-1:0]            fwd_out_q, fwd_out_d;
    logic                        fwd_out_valid_q, fwd_out_valid_d;
    logic [SYM_W-1:0]            bwd_out_q, bwd_out_d;
    logic                        bwd_out_valid_q, bwd_out_valid_d;
    logic                        bwd_miss_q, bwd_miss_d;
    logic [1:0]                  shift_amount_q, shift_amount_d;

    logic [DEPTH-1:0][SYM_W-1:0] grouped, stepped;
    logic [SYM_W-1:0]            cam_idx;
    logic                        cam_miss;
    logic                        load_accept, last_beat, step_accept;

    // clear outranks both load beats and steps in the same cycle.
    assign load_accept = load_valid && (state_q != ST_READY) && !clear;
    assign last_beat   = load_accept && (load_ptr_q == SYM_W'(DEPTH - 1));
    assign step_accept = step && (state_q == ST_READY) && !clear;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (load_valid) state_d = ST_LOAD;
                ST_LOAD:  if (last_beat)  state_d = ST_READY;
                ST_READY: state_d = ST_READY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        load_done = (state_q == ST_READY);
    end

    // ---------------- step permutation ----------------
    always_comb begin
        grouped = '0;
        stepped = '0;
        for (int g = 0; g < DEPTH / GROUP_SIZE; g++) begin
            for (int k = 0; k < GROUP_SIZE; k++) begin
                grouped[GROUP_SIZE*g + k] =
                    tbl_q[GROUP_SIZE*g + int'(swap_src(shift_mode_e'(shift_mode), 2'(k)))];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            stepped[i] = grouped[perm_idx(i, STRIDE, OFFSET, DEPTH)];
        end
    end

    rotor_cam_search #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH)
    ) u_cam (
        .tbl  (tbl_q),
        .key  (bwd_in),
        .idx  (cam_idx),
        .miss (cam_miss)
    );

    // ---------------- table, pointer, counter ----------------
    always_comb begin
        tbl_d      = tbl_q;
        load_ptr_d = load_ptr_q;
        step_cnt_d = step_cnt_q;
        if (clear) begin
            load_ptr_d = '0;
        end else if (load_accept) begin
            tbl_d[load_ptr_q] = load_data;
            load_ptr_d        = load_ptr_q + 1'b1;
            if (last_beat) step_cnt_d = '0;
        end else if (step_accept) begin
            tbl_d      = stepped;
            step_cnt_d = step_cnt_q + 1'b1;
        end
    end

    // ---------------- lookups ----------------
    // Reads come from tbl_q, so a same-cycle step or load beat is not visible.
    always_comb begin
        fwd_out_valid_d = fwd_valid;
        fwd_out_d       = fwd_valid ? tbl_q[fwd_in] : fwd_out_q;
        bwd_out_valid_d = bwd_valid;
        bwd_out_d       = bwd_valid ? cam_idx  : bwd_out_q;
        bwd_miss_d      = bwd_valid ? cam_miss : bwd_miss_q;
        shift_amount_d  = shift_amount_q;
        if (crypt_mode) begin
            if (bwd_valid) shift_amount_d = cam_idx[SYM_W-1 -: 2];
        end else begin
            if (fwd_valid) shift_amount_d = fwd_in[SYM_W-1 -: 2];
        end
    end

    // NOTE: the table is reset along with the rest of the state because
    // lookups are legal in EMPTY and must return defined zeros.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            load_ptr_q      <= '0;
            tbl_q           <= '0;
            step_cnt_q      <= '0;
            fwd_out_q       <= '0;
            fwd_out_valid_q <= 1'b0;
            bwd_out_q       <= '0;
            bwd_out_valid_q <= 1'b0;
            bwd_miss_q      <= 1'b0;
            shift_amount_q  <= '0;
        end else begin
            load_ptr_q      <= load_ptr_d;
            tbl_q           <= tbl_d;
            step_cnt_q      <= step_cnt_d;
            fwd_out_q       <= fwd_out_d;
            fwd_out_valid_q <= fwd_out_valid_d;
            bwd_out_q       <= bwd_out_d;
            bwd_out_valid_q <= bwd_out_valid_d;
            bwd_miss_q      <= bwd_miss_d;
            shift_amount_q  <= shift_amount_d;
        end
    end

    assign fwd_out       = fwd_out_q;
    assign fwd_out_valid = fwd_out_valid_q;
    assign bwd_out       = bwd_out_q;
    assign bwd_out_valid = bwd_out_valid_q;
    assign bwd_miss      = bwd_miss_q;
    assign shift_amount  = shift_amount_q;
    assign step_cnt      = step_cnt_q;

endmodule

// File: tb/tb_rotor_perm_param.sv
// Self-checking bench for rotor_perm_param: a reference model of the table
// and FSM produces expected lookup results that are queued at request time
// and compared by a monitor when the DUT raises its valid strobes.
module tb_rotor_perm_param;

    localparam int SYM_W  = 6;
    localparam int STRIDE = 5;
    localparam int OFFSET = 3;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 64;

    typedef struct {
        logic [SYM_W-1:0] idx;
        logic             miss;
    } bwd_exp_t;

    logic             clk = 1'b0;
    logic             srst_n = 1'b0;
    logic             clear = 1'b0;
    logic             load_valid = 1'b0;
    logic [SYM_W-1:0] load_data = '0;
    logic             load_done;
    logic             step = 1'b0;
    logic [1:0]       shift_mode = 2'd0;
    logic             crypt_mode = 1'b0;
    logic             fwd_valid = 1'b0;
    logic [SYM_W-1:0] fwd_in = '0;
    logic [SYM_W-1:0] fwd_out;
    logic             fwd_out_valid;
    logic             bwd_valid = 1'b0;
    logic [SYM_W-1:0] bwd_in = '0;
    logic [SYM_W-1:0] bwd_out;
    logic             bwd_out_valid;
    logic             bwd_miss;
    logic [1:0]       shift_amount;
    logic [CNT_W-1:0] step_cnt;

    int checks = 0;
    int errors = 0;

    // reference model
    int         mdl[DEPTH];
    int         mstate;     // 0 EMPTY, 1 LOAD, 2 READY
    int         mptr;
    int         mcnt;
    logic [1:0] mshift;

    logic [SYM_W-1:0] fwd_q[$];
    bwd_exp_t         bwd_q[$];

    int ident[DEPTH];
    int fives[DEPTH];

    rotor_perm_param #(
        .SYM_W  (SYM_W),
        .STRIDE (STRIDE),
        .OFFSET (OFFSET),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .srst_n        (srst_n),
        .clear         (clear),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_done     (load_done),
        .step          (step),
        .shift_mode    (shift_mode),
        .crypt_mode    (crypt_mode),
        .fwd_valid     (fwd_valid),
        .fwd_in        (fwd_in),
        .fwd_out       (fwd_out),
        .fwd_out_valid (fwd_out_valid),
        .bwd_valid     (bwd_valid),
        .bwd_in        (bwd_in),
        .bwd_out       (bwd_out),
        .bwd_out_valid (bwd_out_valid),
        .bwd_miss      (bwd_miss),
        .shift_amount  (shift_amount),
        .step_cnt      (step_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin : monitor
        logic [SYM_W-1:0] fe;
        bwd_exp_t         be;
        #1;
        if (srst_n) begin
            if (fwd_out_valid) begin
                checks++;
                if (fwd_q.size() == 0) begin
                    errors++;
                    $display("FAIL fwd_unexpected_valid got fwd_out_valid=1 want 0");
                end else begin
                    fe = fwd_q.pop_front();
                    if (fwd_out !== fe) begin
                        errors++;
                        $display("FAIL fwd_data got %0d want %0d", fwd_out, fe);
                    end
                end
            end
            if (bwd_out_valid) begin
                checks++;
                if (bwd_q.size() == 0) begin
                    errors++;
                    $display("FAIL bwd_unexpected_valid got bwd_out_valid=1 want 0");
                end else begin
                    be = bwd_q.pop_front();
                    if (bwd_out !== be.idx || bwd_miss !== be.miss) begin
                        errors++;
                        $display("FAIL bwd_data got idx=%0d miss=%0b want idx=%0d miss=%0b",
                                 bwd_out, bwd_miss, be.idx, be.miss);
                    end
                end
            end
        end
    end

    // ---------------- model helpers ----------------
    function automatic void model_step(input int mode);
        int maps[4][4] = '{'{1, 3, 0, 2}, '{2, 0, 3, 1}, '{1, 2, 3, 0}, '{0, 3, 2, 1}};
        int tmp[DEPTH];
        for (int i = 0; i < DEPTH; i++) tmp[i] = mdl[(i / 4) * 4 + maps[mode][i % 4]];
        for (int i = 0; i < DEPTH; i++) mdl[i] = tmp[(i * STRIDE + OFFSET) % DEPTH];
    endfunction

    function automatic bwd_exp_t model_bwd(input int v);
        bwd_exp_t r;
        r.idx  = '0;
        r.miss = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (r.miss && mdl[i] == v) begin
                r.idx  = SYM_W'(i);
                r.miss = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic req_fwd_exp(input int idx, input int exp);
        fwd_valid = 1'b1;
        fwd_in    = SYM_W'(idx);
        fwd_q.push_back(SYM_W'(exp));
        if (!crypt_mode) mshift = fwd_in[SYM_W-1 -: 2];
    endtask

    task automatic req_fwd(input int idx);
        req_fwd_exp(idx, mdl[idx]);
    endtask

    task automatic req_bwd(input int v);
        bwd_exp_t e;
        e = model_bwd(v);
        bwd_valid = 1'b1;
        bwd_in    = SYM_W'(v);
        bwd_q.push_back(e);
        if (crypt_mode) mshift = e.idx[SYM_W-1 -: 2];
    endtask

    // Applies the model effect of the currently driven strobes, then clocks.
    task automatic tick();
        if (clear) begin
            mstate = 0;
            mptr   = 0;
        end else if (load_valid && mstate != 2) begin
            mdl[mptr] = int'(load_data);
            if (mptr == DEPTH - 1) begin
                mstate = 2;
                mcnt   = 0;
            end else begin
                mstate = 1;
            end
            mptr = (mptr + 1) % DEPTH;
        end else if (step && mstate == 2) begin
            model_step(int'(shift_mode));
            mcnt = (mcnt + 1) % (1 << CNT_W);
        end
        @(posedge clk);
        #1;
        clear      = 1'b0;
        load_valid = 1'b0;
        step       = 1'b0;
        fwd_valid  = 1'b0;
        bwd_valid  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        srst_n = 1'b0;
        clear = 1'b0; load_valid = 1'b0; step = 1'b0; fwd_valid = 1'b0; bwd_valid = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 0;
        mstate = 0; mptr = 0; mcnt = 0; mshift = 2'd0;
        fwd_q.delete();
        bwd_q.delete();
        checks++;
        if (load_done !== 1'b0) begin
            errors++; $display("FAIL reset_load_done got %0b want 0", load_done);
        end
        checks++;
        if (fwd_out !== '0 || fwd_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_fwd got out=%0d valid=%0b want 0 0", fwd_out, fwd_out_valid);
        end
        checks++;
        if (bwd_out !== '0 || bwd_out_valid !== 1'b0 || bwd_miss !== 1'b0) begin
            errors++;
            $display("FAIL reset_bwd got out=%0d valid=%0b miss=%0b want 0 0 0",
                     bwd_out, bwd_out_valid, bwd_miss);
        end
        checks++;
        if (shift_amount !== 2'd0 || step_cnt !== '0) begin
            errors++;
            $display("FAIL reset_shift_cnt got shift=%0d cnt=%0d want 0 0", shift_amount, step_cnt);
        end
        @(posedge clk);
        #1;
        srst_n = 1'b1;
    endtask

    task automatic load_table(input int vals[DEPTH]);
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1'b1;
            load_data  = SYM_W'(vals[i]);
            if (i == 0) req_fwd(0);    // same index as the beat: pre-write value
            tick();
            if (i == DEPTH - 2) begin
                checks++;
                if (load_done !== 1'b0) begin
                    errors++; $display("FAIL load_done_early got %0b want 0", load_done);
                end
            end
        end
        checks++;
        if (load_done !== 1'b1 || step_cnt !== '0) begin
            errors++;
            $display("FAIL load_done_final got done=%0b cnt=%0d want 1 0", load_done, step_cnt);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_identity_load();
        load_table(ident);
        // a load beat in READY must not change the table
        load_valid = 1'b1;
        load_data  = 6'd63;
        tick();
        req_fwd_exp(10, 10);
        tick();
        req_fwd_exp(0, 0);
        tick();
        tick();
        checks++;
        if (fwd_out !== 6'd0 || fwd_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_hold got out=%0d valid=%0b want 0 0", fwd_out, fwd_out_valid);
        end
    endtask

    task automatic test_step_mode2();
        step       = 1'b1;
        shift_mode = 2'd2;
        tick();
        checks++;
        if (step_cnt !== 16'd1) begin
            errors++; $display("FAIL step_cnt_mode2 got %0d want 1", step_cnt);
        end
        req_fwd_exp(0, 0);
        tick();
        req_fwd_exp(1, 9);
        req_bwd(14);
        bwd_q[bwd_q.size()-1] = '{idx: 6'd2, miss: 1'b0};
        tick();
        req_fwd_exp(2, 14);
        tick();
        tick();
    endtask

    task automatic test_step_with_lookup_and_clear();
        do_clear();
        load_table(ident);
        step       = 1'b1;
        shift_mode = 2'd2;
        req_fwd_exp(1, 1);
        tick();
        req_fwd_exp(1, 9);
        tick();
        checks++;
        if (step_cnt !== 16'd1) begin
            errors++; $display("FAIL step_cnt_same_cycle got %0d want 1", step_cnt);
        end
        clear = 1'b1;
        step  = 1'b1;
        tick();
        checks++;
        if (load_done !== 1'b0 || step_cnt !== 16'd1) begin
            errors++;
            $display("FAIL clear_with_step got done=%0b cnt=%0d want 0 1", load_done, step_cnt);
        end
        req_fwd_exp(1, 9);   // table survives clear
        tick();
        tick();
    endtask

    task automatic test_all_fives();
        load_table(fives);
        req_bwd(5);
        tick();
        req_bwd(6);
        tick();
        tick();
    endtask

    task automatic test_reset_midload();
        do_clear();
        for (int i = 0; i < 20; i++) begin
            load_valid = 1'b1;
            load_data  = SYM_W'(i + 1);
            tick();
        end
        apply_reset();
        step       = 1'b1;
        shift_mode = 2'd1;
        tick();
        checks++;
        if (step_cnt !== '0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL step_in_empty got cnt=%0d done=%0b want 0 0", step_cnt, load_done);
        end
        req_fwd(7);
        req_bwd(0);
        tick();
        req_bwd(3);
        tick();
        tick();
    endtask

    task automatic test_shift_amount();
        do_clear();
        load_table(ident);
        crypt_mode = 1'b0;
        req_fwd_exp(6'h2A, 6'h2A);
        tick();
        checks++;
        if (shift_amount !== 2'b10) begin
            errors++; $display("FAIL shift_fwd got %0b want 10", shift_amount);
        end
        crypt_mode = 1'b1;
        req_fwd_exp(6'h3F, 6'h3F);   // fwd ignored for shift in crypt mode 1
        tick();
        checks++;
        if (shift_amount !== 2'b10) begin
            errors++; $display("FAIL shift_hold got %0b want 10", shift_amount);
        end
        req_bwd(6'h31);
        tick();
        checks++;
        if (shift_amount !== 2'b11) begin
            errors++; $display("FAIL shift_bwd got %0b want 11", shift_amount);
        end
        tick();
    endtask

    task automatic test_random_steps();
        int perm[DEPTH];
        int j, t;
        for (int i = 0; i < DEPTH; i++) perm[i] = i;
        for (int i = DEPTH - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        do_clear();
        load_table(perm);
        for (int s = 0; s < 8; s++) begin
            step       = 1'b1;
            shift_mode = 2'($urandom_range(3, 0));
            req_fwd($urandom_range(DEPTH - 1, 0));
            tick();
            for (int r = 0; r < 3; r++) begin
                crypt_mode = 1'($urandom_range(1, 0));
                req_fwd($urandom_range(DEPTH - 1, 0));
                req_bwd($urandom_range(DEPTH - 1, 0));
                tick();
            end
        end
        tick();
        checks++;
        if (step_cnt !== CNT_W'(mcnt)) begin
            errors++; $display("FAIL random_step_cnt got %0d want %0d", step_cnt, mcnt);
        end
        checks++;
        if (shift_amount !== mshift) begin
            errors++; $display("FAIL random_shift got %0d want %0d", shift_amount, mshift);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ident[i] = i;
            fives[i] = 5;
        end
        test_reset();
        test_identity_load();
        test_step_mode2();
        test_step_with_lookup_and_clear();
        do_clear();
        test_all_fives();
        test_reset_midload();
        test_shift_amount();
        test_random_steps();
        tick();
        tick();
        checks++;
        if (fwd_q.size() != 0 || bwd_q.size() != 0) begin
            errors++;
            $display("FAIL missing_responses got pending fwd=%0d bwd=%0d want 0 0",
                     fwd_q.size(), bwd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotor_perm_param.md
Name: rotor_perm_param

Overview:
Parametrised next-generation rotor for the enigma-style datapath. Holds a DEPTH-entry substitution table of SYM_W-bit symbols, loaded serially. Serves registered forward (index→symbol) and backward (symbol→index) lookups, and steps the table by a mode-selected intra-group swap followed by a parametrised stride permutation. Adds over the previous rotor: width/depth/stride generality, explicit load FSM with done flag, valid-qualified 1-cycle lookups, miss detection, and a step counter.

Parameters:
SYM_W, 6, symbol width; DEPTH = 2**SYM_W (localparam, must be multiple of 4)
STRIDE, 5, global permutation multiplier; must be odd (elaboration-time error otherwise)
OFFSET, 3, global permutation additive offset, 0..DEPTH-1
CNT_W, 16, step counter width

Ports:
clk  in  1  clock, rising edge
srst_n  in  1  reset, asynchronous, active-low
clear  in  1  return to EMPTY, table kept, load pointer zeroed
load_valid  in  1  load beat strobe
load_data  in  SYM_W  table entry for current load pointer
load_done  out  1  table fully loaded (state READY)
step  in  1  advance table by one step
shift_mode  in  2  intra-group swap mode for this step
crypt_mode  in  1  selects source of shift_amount
fwd_valid  in  1  forward lookup request
fwd_in  in  SYM_W  forward index
fwd_out  out  SYM_W  table[fwd_in], registered
fwd_out_valid  out  1  fwd_out valid
bwd_valid  in  1  backward lookup request
bwd_in  in  SYM_W  symbol to search
bwd_out  out  SYM_W  lowest index i with table[i]==bwd_in, else 0
bwd_out_valid  out  1  bwd_out valid
bwd_miss  out  1  no entry matched (qualified by bwd_out_valid)
shift_amount  out  2  rate for upstream rotor
step_cnt  out  CNT_W  steps taken since load completed

Behaviour:
- Reset (async assert, sync-released use): state EMPTY, load pointer 0, table all 0, step_cnt 0; all outputs 0.
- FSM: EMPTY → LOAD on first load_valid; LOAD → READY on beat DEPTH-1 written; READY → EMPTY on clear; clear in any state → EMPTY, pointer 0. clear beats load_valid/step in same cycle.
- Load: each load_valid beat writes table[ptr]=load_data, ptr+1. Beat DEPTH-1 sets load_done next cycle. load_valid in READY ignored. Duplicate values accepted, no check.
- Step: only in READY; ignored elsewhere. Per group g (entries 4g..4g+3), tmp[4g+k]=table[4g+m[k]] with m: mode0 {1,3,0,2}, mode1 {2,0,3,1}, mode2 {1,2,3,0}, mode3 {0,3,2,1}. Then new table[i]=tmp[(i*STRIDE+OFFSET) mod DEPTH]. Takes effect at next edge; step_cnt+1, wraps at 2**CNT_W. step_cnt zeroed on entry to READY.
- Lookups: accepted in any state (return current table contents). 1-cycle latency: outputs registered at edge after request; *_out_valid high exactly one cycle per request; data held while valid low. Lookup and step in same cycle: lookup uses pre-step table. Lookup and load beat to same index: pre-write value.
- Backward: priority search lowest index; miss → bwd_out=0, bwd_miss=1.
- shift_amount registered with lookups: crypt_mode=1 → bwd result [SYM_W-1:SYM_W-2] updated on bwd_valid; crypt_mode=0 → fwd_in [SYM_W-1:SYM_W-2] updated on fwd_valid; else holds.
- Reset mid-load/step: all state discarded, EMPTY.

Decomposition:
- Shared package rotor_pkg: mode encodings (SHIFT_M0..M3), group swap maps, FSM state enum, function perm_idx(i,STRIDE,OFFSET,DEPTH).
- One sub-module: rotor_cam_search (DEPTH-way compare + priority encoder → index, miss).

Test Plan:
- Load identity 0..63 → load_done rises cycle after 64th beat; fwd_in=10 → fwd_out=10, fwd_out_valid one cycle later.
- Identity, step mode2 → step_cnt=1; fwd 0→0, 1→9, 2→14; bwd 14 → bwd_out=2, bwd_miss=0.
- Load all 5s: bwd 5 → 0, miss=0; bwd 6 → 0, miss=1.
- Reset after 20 beats → load_done=0, outputs 0; step in EMPTY → step_cnt stays 0, table unchanged.
- crypt_mode=0, fwd_in=0x2A → shift_amount=2'b10; crypt_mode=1, bwd result 0x31 → 2'b11.
- step + fwd_valid same cycle on identity (mode2) → fwd 1 returns 1, next request returns 9; clear with step → EMPTY, step_cnt unchanged.
